pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Gates the write-enables of PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards and inserts one bubble.
- Redirects and flushes on a taken branch or jump resolved in MEM.
- Freezes the whole pipeline during a variable-latency data-memory access via a req/ack handshake, with a timeout watchdog.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared types and constants for the pipeline hazard control
// Revision     : 1.0
// ============================================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int         MEM_TIMEOUT_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_if : hazard controller <-> pipeline signal bundle
// Revision                : 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             rs_ID;
  logic [4:0]             rt_ID;
  logic                   uses_rt_ID;
  logic                   MemRead_EX;
  logic [4:0]             Write_register_EX;
  logic                   Branch_MEM;
  logic                   Zero_MEM;
  logic                   Jump_MEM;
  logic                   MemRead_MEM;
  logic                   MemWrite_MEM;
  logic                   dmem_ack;
  logic                   dmem_req;
  logic                   PC_write;
  logic                   IF_ID_write;
  logic                   ID_EX_write;
  logic                   EX_MEM_write;
  logic                   ID_EX_bubble;
  logic                   flush_IF_ID;
  logic                   flush_ID_EX;
  logic                   flush_EX_MEM;
  logic                   PCSrc;
  logic                   mem_error;
  logic [STALL_CNT_W-1:0] stall_count;

  // Controller side
  modport master (
    input  rs_ID, rt_ID, uses_rt_ID, MemRead_EX, Write_register_EX,
           Branch_MEM, Zero_MEM, Jump_MEM, MemRead_MEM, MemWrite_MEM, dmem_ack,
    output dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
           ID_EX_bubble, flush_IF_ID, flush_ID_EX, flush_EX_MEM, PCSrc,
           mem_error, stall_count
  );

  // Pipeline side
  modport slave (
    output rs_ID, rt_ID, uses_rt_ID, MemRead_EX, Write_register_EX,
           Branch_MEM, Zero_MEM, Jump_MEM, MemRead_MEM, MemWrite_MEM, dmem_ack,
    input  dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
           ID_EX_bubble, flush_IF_ID, flush_ID_EX, flush_EX_MEM, PCSrc,
           mem_error, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// hazard_detect : combinational load-use compare between EX load and ID sources
// Revision      : 1.0
// ============================================================================
module hazard_detect
  import pipeline_pkg::*;
(
  input  wire logic [4:0] rs_id_i,
  input  wire logic [4:0] rt_id_i,
  input  wire logic       uses_rt_i,
  input  wire logic       mem_read_ex_i,
  input  wire logic [4:0] wr_ex_i,
  output logic            load_use_o
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (wr_ex_i == rs_id_i);
  assign w_rt_match = uses_rt_i && (wr_ex_i == rt_id_i);

  // r0 is hardwired to zero, so a load targeting it never produces a usable value
  assign load_use_o = mem_read_ex_i && (wr_ex_i != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer with dmem wait and timeout watchdog
// Revision             : 1.0
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int STALL_CNT_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pipeline_hazard_ctrl_if.master hz
);

  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   mem_error_q, mem_error_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic w_mem_op;
  logic w_redirect;
  logic w_load_use;
  logic w_advance;
  logic w_pc_write;

  assign w_mem_op   = hz.MemRead_MEM | hz.MemWrite_MEM;
  assign w_redirect = (hz.Branch_MEM & hz.Zero_MEM) | hz.Jump_MEM;

  hazard_detect u_hazard_detect (
    .rs_id_i       (hz.rs_ID),
    .rt_id_i       (hz.rt_ID),
    .uses_rt_i     (hz.uses_rt_ID),
    .mem_read_ex_i (hz.MemRead_EX),
    .wr_ex_i       (hz.Write_register_EX),
    .load_use_o    (w_load_use)
  );

  // The pipeline may move this cycle unless a data access is still outstanding
  assign w_advance = (state_q == RUN)      ? (!w_mem_op || hz.dmem_ack) :
                     (state_q == MEM_WAIT) ? hz.dmem_ack : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (w_mem_op && !hz.dmem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == c_wait_last) begin
          state_d     = ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  assign stall_cnt_d = (!w_pc_write && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
                     ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_comb begin
    hz.dmem_req     = 1'b0;
    w_pc_write      = 1'b0;
    hz.IF_ID_write  = 1'b0;
    hz.ID_EX_write  = 1'b0;
    hz.EX_MEM_write = 1'b0;
    hz.ID_EX_bubble = 1'b0;
    hz.flush_IF_ID  = 1'b0;
    hz.flush_ID_EX  = 1'b0;
    hz.flush_EX_MEM = 1'b0;
    hz.PCSrc        = 1'b0;
    if (rst_n && (state_q != ERROR)) begin
      hz.dmem_req = (state_q == MEM_WAIT) || w_mem_op;
      if (w_advance) begin
        if (w_redirect) begin
          w_pc_write      = 1'b1;
          hz.IF_ID_write  = 1'b1;
          hz.ID_EX_write  = 1'b1;
          hz.EX_MEM_write = 1'b1;
          hz.PCSrc        = 1'b1;
          hz.flush_IF_ID  = 1'b1;
          hz.flush_ID_EX  = 1'b1;
          hz.flush_EX_MEM = 1'b1;
        end else if (w_load_use) begin
          hz.ID_EX_write  = 1'b1;
          hz.EX_MEM_write = 1'b1;
          hz.ID_EX_bubble = 1'b1;
        end else begin
          w_pc_write      = 1'b1;
          hz.IF_ID_write  = 1'b1;
          hz.ID_EX_write  = 1'b1;
          hz.EX_MEM_write = 1'b1;
        end
      end
    end
  end

  assign hz.PC_write    = w_pc_write;
  assign hz.mem_error   = mem_error_q;
  assign hz.stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : scoreboard bench with a behavioural hazard model
// Revision                : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT   = 4;
  localparam int SW        = 4;
  localparam int STALL_MAX = (1 << SW) - 1;

  typedef struct packed {
    logic          req, pcw, ifw, idw, exw, bub, fif, fid, fex, pcsrc, err;
    logic [SW-1:0] stall;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(SW)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .STALL_CNT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  out_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: "dead" = watchdog fired, "waiting" = access outstanding
  bit m_dead, m_waiting;
  int m_wc, m_stalls;

  always @(negedge clk) begin
    out_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{hz.dmem_req, hz.PC_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write,
            hz.ID_EX_bubble, hz.flush_IF_ID, hz.flush_ID_EX, hz.flush_EX_MEM,
            hz.PCSrc, hz.mem_error, hz.stall_count};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: actual=%h required=%h (req,pcw,ifw,idw,exw,bub,fif,fid,fex,pcsrc,err,stall)",
                 $time, a, e);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mre, input logic [4:0] wr,
                      input logic br, input logic z, input logic j,
                      input logic mrm, input logic mwm, input logic ack);
    out_t e;
    bit   memop, redir, lu, busy, done;
    @(posedge clk);
    #1;
    rst_n = rst;
    hz.rs_ID = rs; hz.rt_ID = rt; hz.uses_rt_ID = urt; hz.MemRead_EX = mre;
    hz.Write_register_EX = wr; hz.Branch_MEM = br; hz.Zero_MEM = z; hz.Jump_MEM = j;
    hz.MemRead_MEM = mrm; hz.MemWrite_MEM = mwm; hz.dmem_ack = ack;
    e = '0;
    if (!rst) begin
      m_dead = 0; m_waiting = 0; m_wc = 0; m_stalls = 0;
    end else begin
      memop = mrm || mwm;
      redir = (br && z) || j;
      lu    = mre && (wr != 0) && ((wr == rs) || (urt && (wr == rt)));
      e.err   = m_dead;
      e.stall = SW'(m_stalls);
      if (!m_dead) begin
        busy  = m_waiting || memop;
        done  = !busy || ack;
        e.req = busy;
        if (!done) begin
          if (!m_waiting) begin
            m_waiting = 1; m_wc = 1;
          end else if (m_wc == TIMEOUT - 1) begin
            m_dead = 1;
          end else begin
            m_wc++;
          end
        end else begin
          m_waiting = 0; m_wc = 0;
          if (redir) begin
            {e.pcw, e.ifw, e.idw, e.exw} = 4'hF;
            {e.pcsrc, e.fif, e.fid, e.fex} = 4'hF;
          end else if (lu) begin
            e.idw = 1; e.exw = 1; e.bub = 1;
          end else begin
            {e.pcw, e.ifw, e.idw, e.exw} = 4'hF;
          end
        end
      end
      if (!e.pcw && m_stalls < STALL_MAX) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hz.rs_ID = '0; hz.rt_ID = '0; hz.uses_rt_ID = 0; hz.MemRead_EX = 0;
    hz.Write_register_EX = '0; hz.Branch_MEM = 0; hz.Zero_MEM = 0; hz.Jump_MEM = 0;
    hz.MemRead_MEM = 0; hz.MemWrite_MEM = 0; hz.dmem_ack = 0;

    //   rst rs rt urt mre wr br z  j  mrm mwm ack
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);   // load-use on rs
    idle(1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // r0 never stalls
    step(1, 1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0);   // rt not read
    step(1, 1, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0);   // rt read -> stall
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // taken branch
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // not taken
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // jump
    step(1, 3, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0);   // redirect beats load-use
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);   // ack ends the wait
    idle(1);
    step(1, 2, 0, 0, 1, 2, 0, 0, 0, 1, 0, 1);   // zero-wait access with load-use
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);   // jump on ack cycle
    for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // timeout, saturate
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);   // ack ignored once dead
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   // reset mid-wait
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) >= 3),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 20), 1'($urandom), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 45));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
